// File: rtl/bcd_counter_ndigit.sv
// bcd_counter_ndigit: cascaded N-digit up/down BCD counter with parallel load, wrap or saturate at terminal count.
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   enable    count request; up selects increment (1) or decrement (0)
//   load      synchronous load of load_val, rejected if any nibble exceeds 9
//   bcd       registered count, nibble k is digit k
//   carry_out combinational cascade enable (enabled, not loading, at terminal)
//   tc_hit    registered flag: terminal-count event on the previous edge
//   load_err  registered flag: previous load rejected
module bcd_counter_ndigit #(
  parameter int DIGITS = 4,
  parameter bit WRAP = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] bcd,
  output logic                carry_out,
  output logic                tc_hit,
  output logic                load_err
);
  logic [DIGITS-1:0] at_end;
  logic [DIGITS:0] ripple;
  logic [DIGITS-1:0] bad;
  logic [4*DIGITS-1:0] stepped;
  logic at_tc, load_ok;
  // ripple[k]: every digit below k sits at its rollover value, so digit k moves
  assign ripple[0] = 1'b1;
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    logic [3:0] cur;
    assign cur = bcd[4*d +: 4];
    assign at_end[d] = up ? cur == 4'd9 : cur == 4'd0;
    assign ripple[d+1] = ripple[d] & at_end[d];
    assign bad[d] = load_val[4*d +: 4] > 4'd9;
    assign stepped[4*d +: 4] = !ripple[d] ? cur : at_end[d] ? (up ? 4'd0 : 4'd9) : up ? cur + 4'd1 : cur - 4'd1;
  end
  assign at_tc = ripple[DIGITS];
  assign load_ok = ~|bad;
  assign carry_out = enable & ~load & at_tc;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd <= '0;
      tc_hit <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tc_hit <= carry_out;
      load_err <= load & ~load_ok;
      if (load) begin
        if (load_ok) bcd <= load_val;
      end else if (enable && !(at_tc && !WRAP)) begin
        bcd <= stepped;
      end
    end
  end
endmodule
